// File: rtl/arith_pkg.sv
// Shared arithmetic constants for datapath leaf cells.
//   ADDER_GROUP : carry-lookahead group size in bits
//   ADDER_WIDTH : default operand width of full_adder
package arith_pkg;

   localparam int unsigned ADDER_GROUP = 4;
   localparam int unsigned ADDER_WIDTH = 16;

endpackage : arith_pkg

// File: rtl/cla4_group.sv
// 4-bit carry-lookahead group. Computes the 4-bit sum from the group carry-in
// and exports group generate/propagate for the inter-group lookahead chain.
// Ports:
//   a, b   : 4-bit operand slices
//   c_in   : carry into bit 0 of this group
//   sum    : 4-bit sum slice
//   g_grp  : group generate (group produces a carry regardless of c_in)
//   p_grp  : group propagate (group passes c_in straight through)
module cla4_group (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       g_grp,
   output logic       p_grp
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   always_comb begin
      g = a & b;
      p = a ^ b;

      // Every internal carry is a flat sum-of-products of c_in, so no carry
      // ripples through a neighbouring bit inside the group.
      c[0] = c_in;
      c[1] = g[0] | (p[0] & c_in);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c_in);

      sum = p ^ c;

      g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
      p_grp = &p;
   end

endmodule : cla4_group

// File: rtl/full_adder.sv
// Registered WIDTH-bit unsigned adder: {c_out, s} <= a + b + c_in.
// Built from 4-bit carry-lookahead groups chained via group generate/propagate.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears s and c_out
//   a, b  : unsigned operands
//   c_in  : carry-in
//   s     : registered sum (low WIDTH bits)
//   c_out : registered carry-out (bit WIDTH)
module full_adder
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = ADDER_WIDTH,  // multiple of GROUP, >= GROUP
   parameter int unsigned GROUP = ADDER_GROUP   // fixed: cla4_group is 4 bits wide
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] s,
   output logic             c_out
);

   localparam int unsigned NGROUP = WIDTH / GROUP;

   logic [NGROUP:0]   c_grp;
   logic [NGROUP-1:0] g_grp;
   logic [NGROUP-1:0] p_grp;
   logic [WIDTH-1:0]  sum_d;

   assign c_grp[0] = c_in;

   for (genvar k = 0; k < NGROUP; k++) begin : g_group
      cla4_group u_group (
         .a     (a[k*GROUP +: GROUP]),
         .b     (b[k*GROUP +: GROUP]),
         .c_in  (c_grp[k]),
         .sum   (sum_d[k*GROUP +: GROUP]),
         .g_grp (g_grp[k]),
         .p_grp (p_grp[k])
      );

      assign c_grp[k+1] = g_grp[k] | (p_grp[k] & c_grp[k]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s     <= '0;
         c_out <= 1'b0;
      end else begin
         s     <= sum_d;
         c_out <= c_grp[NGROUP];
      end
   end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder (WIDTH = 16).
module tb_full_adder;

   logic        clk;
   logic        rst;
   logic [15:0] a;
   logic [15:0] b;
   logic        c_in;
   logic [15:0] s;
   logic        c_out;

   int checks;
   int errors;

   full_adder #(
      .WIDTH (16),
      .GROUP (4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .s     (s),
      .c_out (c_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; sampling and driving happen 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      // Prime outputs with non-zero values so the clear is observable.
      rst = 1'b0; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
      tick();
      checks++;
      if ({c_out, s} !== 17'h1FFFF) begin
         errors++;
         $display("FAIL reset_prime got c_out=%0b s=%h want c_out=1 s=ffff", c_out, s);
      end
      a = 16'h1234; b = 16'h4321; c_in = 1'b1;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({c_out, s} !== 17'h00000) begin
         errors++;
         $display("FAIL reset_async got c_out=%0b s=%h want c_out=0 s=0000", c_out, s);
      end
      tick();
      checks++;
      if ({c_out, s} !== 17'h00000) begin
         errors++;
         $display("FAIL reset_held got c_out=%0b s=%h want c_out=0 s=0000", c_out, s);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({c_out, s} !== {1'b0, 16'h5556}) begin
         errors++;
         $display("FAIL reset_release got c_out=%0b s=%h want c_out=0 s=5556", c_out, s);
      end
   endtask

   task automatic test_basic();
      a = 16'h1234; b = 16'h4321; c_in = 1'b0;
      tick();
      checks++;
      if ({c_out, s} !== {1'b0, 16'h5555}) begin
         errors++;
         $display("FAIL basic_1 got c_out=%0b s=%h want c_out=0 s=5555", c_out, s);
      end
   endtask

   task automatic test_back_to_back();
      a = 16'h00FF; b = 16'h0001; c_in = 1'b0;
      tick();
      checks++;
      if ({c_out, s} !== {1'b0, 16'h0100}) begin
         errors++;
         $display("FAIL b2b got c_out=%0b s=%h want c_out=0 s=0100", c_out, s);
      end
   endtask

   task automatic test_full_carry();
      a = 16'hFFFF; b = 16'h0000; c_in = 1'b1;
      tick();
      checks++;
      if ({c_out, s} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL ripple_all got c_out=%0b s=%h want c_out=1 s=0000", c_out, s);
      end
      a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
      tick();
      checks++;
      if ({c_out, s} !== {1'b1, 16'hFFFF}) begin
         errors++;
         $display("FAIL max_sum got c_out=%0b s=%h want c_out=1 s=ffff", c_out, s);
      end
      a = 16'h0000; b = 16'h0000; c_in = 1'b0;
      tick();
      checks++;
      if ({c_out, s} !== {1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL zero_sum got c_out=%0b s=%h want c_out=0 s=0000", c_out, s);
      end
   endtask

   task automatic test_group_boundary();
      a = 16'h000F; b = 16'h0001; c_in = 1'b0;
      tick();
      checks++;
      if ({c_out, s} !== {1'b0, 16'h0010}) begin
         errors++;
         $display("FAIL grp_0_1 got c_out=%0b s=%h want c_out=0 s=0010", c_out, s);
      end
      a = 16'h0FFF; b = 16'h0001; c_in = 1'b0;
      tick();
      checks++;
      if ({c_out, s} !== {1'b0, 16'h1000}) begin
         errors++;
         $display("FAIL grp_2_3 got c_out=%0b s=%h want c_out=0 s=1000", c_out, s);
      end
      a = 16'h8000; b = 16'h8000; c_in = 1'b0;
      tick();
      checks++;
      if ({c_out, s} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL msb_carry got c_out=%0b s=%h want c_out=1 s=0000", c_out, s);
      end
      a = 16'h00F0; b = 16'h0010; c_in = 1'b0;
      tick();
      checks++;
      if ({c_out, s} !== {1'b0, 16'h0100}) begin
         errors++;
         $display("FAIL grp_1_2 got c_out=%0b s=%h want c_out=0 s=0100", c_out, s);
      end
   endtask

   task automatic test_counting_sweep();
      logic [16:0] exp;
      int          bad;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         c_in = i[0];
         a    = 16'(i >> 1);
         b    = 16'(i >> 2);
         exp  = {1'b0, a} + {1'b0, b} + {16'h0000, c_in};
         tick();
         checks++;
         if ({c_out, s} !== exp) begin
            errors++;
            bad++;
            if (bad <= 5)
               $display("FAIL sweep[%0d] got %h want %h", i, {c_out, s}, exp);
         end
      end
   endtask

   task automatic test_random();
      logic [16:0] exp;
      int          bad;
      bad = 0;
      for (int i = 0; i < 10000; i++) begin
         a    = 16'($urandom());
         b    = 16'($urandom());
         c_in = 1'($urandom());
         if ($urandom_range(0, 49) == 0) begin
            #2 rst = 1'b1;
            #1;
            checks++;
            if ({c_out, s} !== 17'h00000) begin
               errors++;
               bad++;
               if (bad <= 5)
                  $display("FAIL rand_rst[%0d] got %h want 00000", i, {c_out, s});
            end
            tick();
            checks++;
            if ({c_out, s} !== 17'h00000) begin
               errors++;
               bad++;
               if (bad <= 5)
                  $display("FAIL rand_rst_hold[%0d] got %h want 00000", i, {c_out, s});
            end
            rst = 1'b0;
         end
         exp = {1'b0, a} + {1'b0, b} + {16'h0000, c_in};
         tick();
         checks++;
         if ({c_out, s} !== exp) begin
            errors++;
            bad++;
            if (bad <= 5)
               $display("FAIL rand[%0d] a=%h b=%h c_in=%0b got %h want %h",
                        i, a, b, c_in, {c_out, s}, exp);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      a      = '0;
      b      = '0;
      c_in   = 1'b0;
      #1;
      checks++;
      if ({c_out, s} !== 17'h00000) begin
         errors++;
         $display("FAIL reset_initial got c_out=%0b s=%h want c_out=0 s=0000", c_out, s);
      end
      tick();
      rst = 1'b0;

      test_reset();
      test_basic();
      test_back_to_back();
      test_full_carry();
      test_group_boundary();
      test_counting_sweep();
      test_random();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_full_adder
